// File: rtl/sha_256_core.sv
// sha_256_core: SHA-256 (optional SHA-224) compression core, one 512-bit
// pre-padded block per request, UNROLL rounds per clock, 16-word schedule
// window computed on the fly; multi-block messages chain through Index.
// Optional feature macro: SHA_224_EN (honours Mode, SHA-224 IV and masking).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   Data[511:0]   block, word i = Data[32*i+31:32*i], word 0 first
//   Index[63:0]   0 = first block (load IV), otherwise chain from H
//   Enable, Mode  request (taken when Ready), 0=SHA-256 / 1=SHA-224
//   Hash[255:0]   {H0..H7}, H0 in [255:224]
//   Ready, Valid  idle flag, one-cycle digest-updated pulse
module sha_256_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] Data,
    input  logic [63:0]  Index,
    input  logic         Enable,
    input  logic         Mode,
    output logic [255:0] Hash,
    output logic         Ready,
    output logic         Valid
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $error("sha_256_core: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [5:0] STEP = 6'(UNROLL);

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

`ifdef SHA_224_EN
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on the packed {a,b,c,d,e,f,g,h} state.
    function automatic logic [255:0] rnd(input logic [255:0] s,
                                         input logic [31:0] k,
                                         input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
               + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
               + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    w_q [16];
    logic [255:0]   wv_q;
    logic [255:0]   h_q;
    logic [255:0]   hash_q;
    logic [5:0]     iter_q;
    logic           valid_q;
    logic           mode_q;
    logic           accept, do_round, do_final, last_round;
    logic [255:0]   iv_sel;
    logic [255:0]   sum;
    logic [255:0]   hash_nxt;
    logic [31:0]    ext [16 + UNROLL];
    logic [255:0]   st [UNROLL + 1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Enable) state_nxt = ROUND;
            ROUND:   if (last_round) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Ready    = (state == IDLE);
        accept   = (state == IDLE) && Enable;
        do_round = (state == ROUND);
        do_final = (state == FINAL);
    end

    assign last_round = ({1'b0, iter_q} + {1'b0, STEP}) == 7'd64;

`ifdef SHA_224_EN
    assign iv_sel = Mode ? IV224 : IV256;
`else
    logic unused_mode;
    assign unused_mode = Mode;
    assign iv_sel = IV256;
`endif

    // Extended window: w_q holds W[t..t+15]; entries 16.. are the next
    // UNROLL schedule words, which later rounds of this cycle never need.
    always_comb begin
        for (int k = 0; k < 16; k++) ext[k] = w_q[k];
        for (int k = 16; k < 16 + UNROLL; k++)
            ext[k] = ssig1(ext[k-2]) + ext[k-7] + ssig0(ext[k-15]) + ext[k-16];
        st[0] = wv_q;
        for (int j = 0; j < UNROLL; j++)
            st[j+1] = rnd(st[j], K[iter_q + 6'(j)], ext[j]);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++)
            sum[32*i +: 32] = h_q[32*i +: 32] + wv_q[32*i +: 32];
    end

`ifdef SHA_224_EN
    assign hash_nxt = mode_q ? {sum[255:32], 32'h0} : sum;
`else
    assign hash_nxt = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) w_q[k] <= '0;
            wv_q    <= '0;
            h_q     <= '0;
            hash_q  <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            valid_q <= do_final;
            if (accept) begin
                for (int k = 0; k < 16; k++) w_q[k] <= Data[32*k +: 32];
                iter_q <= '0;
`ifdef SHA_224_EN
                mode_q <= Mode;
`endif
                if (Index == '0) begin
                    h_q  <= iv_sel;
                    wv_q <= iv_sel;
                end else begin
                    wv_q <= h_q;
                end
            end else if (do_round) begin
                for (int k = 0; k < 16; k++) w_q[k] <= ext[k + UNROLL];
                wv_q   <= st[UNROLL];
                iter_q <= iter_q + STEP;
            end else if (do_final) begin
                h_q    <= sum;
                hash_q <= hash_nxt;
            end
        end
    end

    assign Hash  = hash_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_sha_256_core.sv
// tb_sha_256_core: checks three sha_256_core instances (UNROLL 1/2/4)
// against known digests and a plain SHA-256 reference model.
module tb_sha_256_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] data;
    logic [63:0]  index;
    logic         mode;
    logic [2:0]   en;
    logic [255:0] hash1, hash2, hash4;
    logic         rdy1, rdy2, rdy4;
    logic         vld1, vld2, vld4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha_256_core #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .Data(data), .Index(index), .Enable(en[0]),
        .Mode(mode), .Hash(hash1), .Ready(rdy1), .Valid(vld1));
    sha_256_core #(.UNROLL(2)) u2 (
        .clk(clk), .rst(rst), .Data(data), .Index(index), .Enable(en[1]),
        .Mode(mode), .Hash(hash2), .Ready(rdy2), .Valid(vld2));
    sha_256_core #(.UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .Data(data), .Index(index), .Enable(en[2]),
        .Mode(mode), .Hash(hash4), .Ready(rdy4), .Valid(vld4));

`ifdef SHA_224_EN
    localparam bit HAS224 = 1'b1;
`else
    localparam bit HAS224 = 1'b0;
`endif

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [255:0] ABC256 = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] ABC224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
        32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
    localparam logic [255:0] TWO256 = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    localparam logic [31:0] M1 [16] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic [255:0] model_h;
    logic [255:0] cap_hash [3];
    int           cap_lat  [3];
    int           cap_cnt  [3];

    function automatic int lat_of(input int k);
        case (k)
            0: return 65;
            1: return 33;
            default: return 17;
        endcase
    endfunction

    function automatic logic vld(input int k);
        case (k)
            0: return vld1;
            1: return vld2;
            default: return vld4;
        endcase
    endfunction

    function automatic logic rdy(input int k);
        case (k)
            0: return rdy1;
            1: return rdy2;
            default: return rdy4;
        endcase
    endfunction

    function automatic logic [255:0] hsh(input int k);
        case (k)
            0: return hash1;
            1: return hash2;
            default: return hash4;
        endcase
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression of one block on chaining value hin.
    function automatic logic [255:0] compress(input logic [255:0] hin,
                                              input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++)
            r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] pack16(input logic [31:0] w [16]);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = w[i];
        return d;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [511:0] abc_blk();
        logic [511:0] d;
        d = '0;
        d[31:0] = 32'h61626380;
        d[32*15 +: 32] = 32'h00000018;
        return d;
    endfunction

    function automatic logic [511:0] two_blk2();
        logic [511:0] d;
        d = '0;
        d[32*15 +: 32] = 32'h000001c0;
        return d;
    endfunction

    // Advances the model chaining value and returns the expected Hash.
    task automatic model_block(input logic [511:0] d, input logic [63:0] idx,
                               input logic m, output logic [255:0] exp);
        logic         em;
        logic [255:0] base;
        em = HAS224 && m;
        base = (idx == 64'd0) ? (em ? IV224 : IV256) : model_h;
        model_h = compress(base, d);
        exp = em ? {model_h[255:32], 32'h0} : model_h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [511:0] d, input logic [63:0] idx,
                               input logic m);
        int n;
        n = 0;
        while (!(rdy1 && rdy2 && rdy4) && n < 200) begin
            step();
            n++;
        end
        if (!(rdy1 && rdy2 && rdy4)) begin
            errors++;
            $display("FAIL ready_wait: ready=%b%b%b required 111",
                     rdy1, rdy2, rdy4);
        end
        checks++;
        data = d;
        index = idx;
        mode = m;
        en = 3'b111;
        step();
        en = 3'b000;
        data = rand_blk();
        index = {$urandom, $urandom};
        mode = 1'($urandom);
    endtask

    // Watches all instances for up to 80 cycles after the accept edge.
    task automatic collect(input int already);
        for (int k = 0; k < 3; k++) begin
            cap_cnt[k] = 0;
            cap_lat[k] = -1;
            cap_hash[k] = '0;
        end
        for (int n = already + 1; n <= 80; n++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (vld(k)) begin
                    cap_cnt[k]++;
                    if (cap_cnt[k] == 1) begin
                        cap_lat[k] = n;
                        cap_hash[k] = hsh(k);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 3'b000;
        data = rand_blk();
        index = '0;
        mode = 1'b0;
        step();
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy(k) !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy(k));
            end
            checks++;
            if (vld(k) !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid[%0d]: got %b want 0", k, vld(k));
            end
            checks++;
            if (hsh(k) !== 256'd0) begin
                errors++;
                $display("FAIL reset_hash[%0d]: got %h want 0", k, hsh(k));
            end
        end
        rst = 1'b0;
        model_h = '0;
        step();
    endtask

    task automatic test_abc();
        logic [255:0] exp;
        model_block(abc_blk(), 64'd0, 1'b0, exp);
        start_block(abc_blk(), 64'd0, 1'b0);
        collect(0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_hash[k] !== ABC256) begin
                errors++;
                $display("FAIL abc256[%0d]: got %h want %h", k, cap_hash[k], ABC256);
            end
            checks++;
            if (cap_cnt[k] != 1 || cap_lat[k] != lat_of(k)) begin
                errors++;
                $display("FAIL abc_latency[%0d]: pulses %0d at %0d want 1 at %0d",
                         k, cap_cnt[k], cap_lat[k], lat_of(k));
            end
        end
    endtask

    task automatic test_mode();
        logic [255:0] exp;
        logic [255:0] want;
        model_block(abc_blk(), 64'd0, 1'b1, exp);
        want = HAS224 ? ABC224 : ABC256;
        start_block(abc_blk(), 64'd0, 1'b1);
        collect(0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_hash[k] !== want) begin
                errors++;
                $display("FAIL mode1_abc[%0d]: got %h want %h", k, cap_hash[k], want);
            end
        end
    endtask

    task automatic test_two_block();
        logic [255:0] exp;
        model_block(pack16(M1), 64'd0, 1'b0, exp);
        start_block(pack16(M1), 64'd0, 1'b0);
        collect(0);
        model_block(two_blk2(), 64'd1, 1'b0, exp);
        start_block(two_blk2(), 64'd1, 1'b0);
        collect(0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_hash[k] !== TWO256) begin
                errors++;
                $display("FAIL two_block[%0d]: got %h want %h", k, cap_hash[k], TWO256);
            end
        end
    endtask

    task automatic test_random();
        logic [511:0] d;
        logic [63:0]  idx;
        logic         m;
        logic [255:0] exp;
        for (int b = 0; b < 6; b++) begin
            d = rand_blk();
            idx = (b == 0) ? 64'd0 : {$urandom, $urandom} | 64'd1;
            m = 1'($urandom);
            model_block(d, idx, m, exp);
            start_block(d, idx, m);
            collect(0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cap_hash[k] !== exp || cap_cnt[k] != 1) begin
                    errors++;
                    $display("FAIL random_blk%0d[%0d]: got %h (%0d pulses) want %h",
                             b, k, cap_hash[k], cap_cnt[k], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        logic [255:0] exp_a, exp_b;
        int           phase [3];
        int           t1 [3];
        a = rand_blk();
        b = rand_blk();
        model_block(a, 64'd0, 1'b0, exp_a);
        model_block(b, 64'd0, 1'b0, exp_b);
        start_block(a, 64'd0, 1'b0);
        data = b;
        index = 64'd0;
        mode = 1'b0;
        en = 3'b111;
        for (int k = 0; k < 3; k++) begin
            phase[k] = 0;
            t1[k] = 0;
        end
        for (int n = 1; n <= 200; n++) begin
            if (phase[0] == 3 && phase[1] == 3 && phase[2] == 3) break;
            step();
            for (int k = 0; k < 3; k++) begin
                if (phase[k] == 0 && vld(k)) begin
                    checks++;
                    if (n != lat_of(k) || hsh(k) !== exp_a) begin
                        errors++;
                        $display("FAIL b2b_first[%0d]: at %0d hash %h want at %0d hash %h",
                                 k, n, hsh(k), lat_of(k), exp_a);
                    end
                    t1[k] = n;
                    phase[k] = 1;
                end else if (phase[k] == 1) begin
                    checks++;
                    if (rdy(k) !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_accept[%0d]: ready %b want 0", k, rdy(k));
                    end
                    en[k] = 1'b0;
                    phase[k] = 2;
                end else if (phase[k] == 2 && vld(k)) begin
                    checks++;
                    if (n != 2 * lat_of(k) + 1 || hsh(k) !== exp_b) begin
                        errors++;
                        $display("FAIL b2b_second[%0d]: at %0d hash %h want at %0d hash %h",
                                 k, n, hsh(k), 2 * lat_of(k) + 1, exp_b);
                    end
                    phase[k] = 3;
                end
            end
        end
        en = 3'b000;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (phase[k] != 3) begin
                errors++;
                $display("FAIL b2b_timeout[%0d]: phase %0d want 3", k, phase[k]);
            end
        end
    endtask

    task automatic test_busy_and_reset();
        logic [255:0] exp;
        logic [511:0] d;
        model_block(abc_blk(), 64'd0, 1'b0, exp);
        start_block(abc_blk(), 64'd0, 1'b0);
        for (int n = 0; n < 10; n++) step();
        data = rand_blk();
        index = 64'd0;
        en = 3'b111;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy(k) !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready[%0d]: got %b want 0", k, rdy(k));
            end
        end
        step();
        en = 3'b000;
        collect(11);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_hash[k] !== ABC256 || cap_cnt[k] != 1) begin
                errors++;
                $display("FAIL busy_ignored[%0d]: got %h (%0d pulses) want %h",
                         k, cap_hash[k], cap_cnt[k], ABC256);
            end
        end
        start_block(rand_blk(), 64'd0, 1'b0);
        for (int n = 0; n < 20; n++) step();
        rst = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld(k) !== 1'b0 || rdy(k) !== 1'b1 || hsh(k) !== 256'd0) begin
                errors++;
                $display("FAIL midreset[%0d]: valid %b ready %b hash %h want 0 1 0",
                         k, vld(k), rdy(k), hsh(k));
            end
        end
        rst = 1'b0;
        model_h = '0;
        collect(0);
        checks++;
        if (cap_cnt[0] != 0) begin
            errors++;
            $display("FAIL midreset_novalid: got %0d pulses want 0", cap_cnt[0]);
        end
        d = rand_blk();
        model_block(d, 64'd7, 1'b0, exp);
        start_block(d, 64'd7, 1'b0);
        collect(0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_hash[k] !== exp) begin
                errors++;
                $display("FAIL chain_from_zero[%0d]: got %h want %h", k, cap_hash[k], exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 3'b000;
        data = '0;
        index = '0;
        mode = 1'b0;
        model_h = '0;
        test_reset();
        test_abc();
        test_mode();
        test_two_block();
        test_random();
        test_back_to_back();
        test_busy_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
